iob_eth: RTL and testbench
==========================

Name: iob_eth

Overview:
- Minimal Ethernet MAC with an MII (4-bit) PHY interface and a CPU register/buffer interface.
- CPU fills a TX byte buffer with a complete frame (preamble, SFD, header, payload) and issues SEND. The block serialises the frame nibble-wise, appending a CRC-32 FCS.
- Received frames are de-preambled, address-filtered and stored in an RX byte buffer for the CPU to read, then released with RCVACK.

Parameters:
- ADDR_W, 12, CPU address width.
- BUF_W, 11, log2 of TX and RX buffer depth in bytes (2048 each).
- MAC_ADDR, 48'h01606e11020f, station address used for RX filtering.
- Register map (word addresses): STATUS=0, SEND=1, RCVACK=2, TX_NBYTES=3, RX_NBYTES=4. DATA base=2048; DATA+i is buffer byte i.

Ports:
- clk  in  1  system clock; the only clock of the block.
- rst  in  1  synchronous active-high reset.
- sel  in  1  CPU access select.
- we  in  1  write enable, qualified by sel.
- addr  in  ADDR_W  register/buffer address.
- data_in  in  32  write data.
- data_out  out  32  registered read data.
- ETH_RESETN  out  1  PHY reset, active low.
- TX_CLK  in  1  PHY transmit clock, sampled as data.
- TX_DATA  out  4  transmit nibble.
- TX_EN  out  1  transmit enable.
- RX_CLK  in  1  PHY receive clock, sampled as data.
- RX_DATA  in  4  receive nibble.
- RX_DV  in  1  receive data valid.

Behaviour:
- Clocking and reset
  - One clock (clk); reset is synchronous and active-high.
  - TX_CLK and RX_CLK are 2-flop synchronised and edge-detected inside the clk domain. Requires clk >= 3x PHY clock.
  - Reset values: data_out=0, TX_EN=0, TX_DATA=0, ETH_RESETN=0, tx_ready=1, rx_ready=0, TX_NBYTES=0, RX_NBYTES=0.
  - ETH_RESETN is registered ~rst: goes 1 one cycle after rst deasserts.
- CPU writes (sel=1, we=1, single cycle)
  - TX_NBYTES, RX_NBYTES: store data_in[BUF_W-1:0].
  - SEND with data_in[0]=1 starts transmission only if tx_ready=1; otherwise ignored.
  - RCVACK with data_in[0]=1 clears rx_ready and re-arms the receiver.
  - DATA+i writes data_in[7:0] to TX buffer byte i.
  - Writes to unmapped addresses are ignored.
- CPU reads (sel=1, we=0)
  - data_out is registered from addr at each posedge, so it is valid one cycle after sel/addr are applied.
  - STATUS returns {30'b0, rx_ready, tx_ready}.
  - TX_NBYTES and RX_NBYTES read back their stored values.
  - DATA+i returns {24'b0, RX buffer byte i}.
  - Other addresses return 0.
- Transmitter
  - States IDLE, DATA, FCS.
  - SEND clears tx_ready. Transmits TX buffer bytes 0 to 30+TX_NBYTES-1, then 4 FCS bytes.
  - Each byte is sent low nibble first. TX_DATA/TX_EN update on the detected falling edge of TX_CLK.
  - FCS is CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final inversion). It covers bytes 16 onward (after SFD) and is sent LSB byte first.
  - After the last nibble, TX_EN=0 at the next falling edge and tx_ready=1.
- Receiver
  - States IDLE, PREAMBLE, DATA, DONE.
  - Samples RX_DATA/RX_DV on the detected rising edge of RX_CLK.
  - Active only when rx_ready=0.
  - Hunts for the SFD byte 0xD5, assembled low nibble first, while RX_DV=1.
  - Stores subsequent bytes at RX buffer index 0,1,2,... until RX_DV falls. Writes are clipped at 2^BUF_W bytes; further bytes are discarded.
  - On RX_DV fall, rx_ready=1 only if both:
    - destination MAC (bytes 0-5) equals MAC_ADDR or FF:FF:FF:FF:FF:FF;
    - byte count >= RX_NBYTES+18.
  - Otherwise the frame is dropped and the receiver returns to IDLE.
  - RX_DV deassert before SFD returns to IDLE.
  - Frames arriving while rx_ready=1 are ignored entirely.
  - No FCS check; the 4 FCS bytes are stored after the payload.
- Simultaneous events
  - CPU buffer writes during TX affect bytes not yet sent.
  - RCVACK in the same cycle as a frame completion: the completion wins (rx_ready=1).
- Reset mid-frame aborts TX/RX immediately and applies reset values.

Test Plan:
- Reset: hold rst 10 cycles -> STATUS=1, TX_EN=0, ETH_RESETN=0; one cycle after release ETH_RESETN=1.
- Loopback (RX_DATA=TX_DATA, RX_DV=TX_EN, RX_CLK=TX_CLK=25 MHz, clk=100 MHz), in order:
  - Set TX_NBYTES=RX_NBYTES=64 and write the 94-byte frame: 15x0x55, 0xD5, dst=src=MAC_ADDR, type 0x0800, payload 1..64.
  - SEND -> STATUS bit0 drops, then returns to 1.
  - STATUS bit1 rises; DATA+0..77 equal frame bytes 16..93; DATA+78..81 hold the correct FCS.
- RCVACK write -> STATUS bit1=0; a second SEND is received again correctly.
- Destination MAC 02:00:00:00:00:01 -> frame transmitted, STATUS bit1 stays 0. Broadcast destination -> accepted.
- SEND while tx_ready=0 -> ignored, TX_EN pulse count is 1. Frame shorter than RX_NBYTES+18 -> dropped.
- Register readback: write TX_NBYTES=100 -> read returns 100 one cycle later. Unmapped address reads 0.

Source files
------------

// File: rtl/iob_eth_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : iob_eth_if
// Brief    : CPU register/buffer bus of the iob_eth MAC.
// Revision : 1.0 - initial release
// ============================================================================
interface iob_eth_if #(
    parameter int ADDR_W = 12
) ();
    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_in;
    logic [31:0]       data_out;

    modport master (output sel, we, addr, data_in, input data_out);
    modport slave  (input sel, we, addr, data_in, output data_out);
endinterface
`default_nettype wire

// File: rtl/iob_eth.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : iob_eth
// Brief    : Minimal MII Ethernet MAC with CPU-mapped TX/RX byte buffers.
// Revision : 1.0 - initial release
// ============================================================================
module iob_eth #(
    parameter int          ADDR_W   = 12,
    parameter int          BUF_W    = 11,
    parameter logic [47:0] MAC_ADDR = 48'h01606e11020f
) (
    input  wire         clk,
    input  wire         rst,
    iob_eth_if.slave    cpu,
    output logic        ETH_RESETN,
    input  wire         TX_CLK,
    output logic [3:0]  TX_DATA,
    output logic        TX_EN,
    input  wire         RX_CLK,
    input  wire  [3:0]  RX_DATA,
    input  wire         RX_DV
);
    localparam logic [ADDR_W-1:0] c_status    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_send      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_rcvack    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_tx_nbytes = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_rx_nbytes = ADDR_W'(4);
    localparam logic [31:0]       c_crc_poly  = 32'hEDB88320;

    typedef enum logic [1:0] {S_TX_IDLE, S_TX_DATA, S_TX_FCS} tx_state_t;
    typedef enum logic [1:0] {S_RX_IDLE, S_RX_PRE, S_RX_DATA, S_RX_DONE} rx_state_t;

    tx_state_t        r_tx_state, w_tx_state_nxt;
    rx_state_t        r_rx_state, w_rx_state_nxt;
    logic [2:0]       r_txc_sync, r_rxc_sync;
    logic [7:0]       r_tx_mem [0:(2**BUF_W)-1];
    logic [7:0]       r_rx_mem [0:(2**BUF_W)-1];
    logic [BUF_W-1:0] r_tx_nbytes, r_rx_nbytes;
    logic [31:0]      r_data_out, r_crc, w_fcs;
    logic             r_tx_ready, r_rx_ready, r_tx_nib, r_rx_nib, r_mac_ok, r_bc_ok;
    logic [BUF_W:0]   r_tx_idx, w_tx_last, r_rx_cnt;
    logic [3:0]       r_fcs_cnt, w_fcs_nib, r_rx_prev;
    logic [7:0]       w_tx_byte, w_rx_byte, w_mac_byte;
    logic             w_tx_fall, w_rx_rise, w_wr, w_is_data, w_send, w_rcvack;
    logic             w_rx_wr, w_rx_accept, w_unused_bits;
    logic [BUF_W-1:0] w_buf_idx;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
        return c;
    endfunction

    // PHY clocks are treated as data: synchronise, then detect edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txc_sync <= 3'd0;
            r_rxc_sync <= 3'd0;
            ETH_RESETN <= 1'b0;
        end else begin
            r_txc_sync <= {r_txc_sync[1:0], TX_CLK};
            r_rxc_sync <= {r_rxc_sync[1:0], RX_CLK};
            ETH_RESETN <= 1'b1;
        end
    end
    assign w_tx_fall = r_txc_sync[2] & ~r_txc_sync[1];
    assign w_rx_rise = ~r_rxc_sync[2] & r_rxc_sync[1];

    assign w_wr          = cpu.sel & cpu.we;
    assign w_is_data     = (cpu.addr[ADDR_W-1:BUF_W] == (ADDR_W-BUF_W)'(1));
    assign w_buf_idx     = cpu.addr[BUF_W-1:0];
    assign w_send        = w_wr && (cpu.addr == c_send) && cpu.data_in[0] && r_tx_ready;
    assign w_rcvack      = w_wr && (cpu.addr == c_rcvack) && cpu.data_in[0];
    assign w_unused_bits = ^cpu.data_in[31:BUF_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_nbytes <= '0;
            r_rx_nbytes <= '0;
        end else if (w_wr && cpu.addr == c_tx_nbytes) begin
            r_tx_nbytes <= cpu.data_in[BUF_W-1:0];
        end else if (w_wr && cpu.addr == c_rx_nbytes) begin
            r_rx_nbytes <= cpu.data_in[BUF_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && w_is_data) r_tx_mem[w_buf_idx] <= cpu.data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_is_data) begin
            r_data_out <= {24'd0, r_rx_mem[w_buf_idx]};
        end else begin
            case (cpu.addr)
                c_status:    r_data_out <= {30'd0, r_rx_ready, r_tx_ready};
                c_tx_nbytes: r_data_out <= 32'(r_tx_nbytes);
                c_rx_nbytes: r_data_out <= 32'(r_rx_nbytes);
                default:     r_data_out <= '0;
            endcase
        end
    end
    assign cpu.data_out = r_data_out;

    // Frame occupies TX buffer bytes 0 .. 29+TX_NBYTES (16 preamble/SFD + 14 header + payload).
    assign w_tx_last = (BUF_W+1)'(29) + {1'b0, r_tx_nbytes};
    assign w_tx_byte = r_tx_mem[r_tx_idx[BUF_W-1:0]];
    assign w_fcs     = ~r_crc;
    assign w_fcs_nib = w_fcs[{r_fcs_cnt[2:0], 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= S_TX_IDLE;
        else     r_tx_state <= w_tx_state_nxt;
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            S_TX_IDLE: if (w_send) w_tx_state_nxt = S_TX_DATA;
            S_TX_DATA: if (w_tx_fall && r_tx_nib && r_tx_idx == w_tx_last) w_tx_state_nxt = S_TX_FCS;
            S_TX_FCS:  if (w_tx_fall && r_fcs_cnt == 4'd8) w_tx_state_nxt = S_TX_IDLE;
            default:   w_tx_state_nxt = S_TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            TX_EN      <= 1'b0;
            TX_DATA    <= 4'd0;
            r_tx_ready <= 1'b1;
            r_tx_idx   <= '0;
            r_tx_nib   <= 1'b0;
            r_fcs_cnt  <= 4'd0;
            r_crc      <= '1;
        end else begin
            case (r_tx_state)
                S_TX_IDLE: if (w_send) begin
                    r_tx_ready <= 1'b0;
                    r_tx_idx   <= '0;
                    r_tx_nib   <= 1'b0;
                    r_fcs_cnt  <= 4'd0;
                    r_crc      <= '1;
                end
                S_TX_DATA: if (w_tx_fall) begin
                    TX_EN    <= 1'b1;
                    TX_DATA  <= r_tx_nib ? w_tx_byte[7:4] : w_tx_byte[3:0];
                    r_tx_nib <= ~r_tx_nib;
                    if (r_tx_nib) begin
                        r_tx_idx <= r_tx_idx + (BUF_W+1)'(1);
                        if (r_tx_idx >= (BUF_W+1)'(16)) r_crc <= crc32_byte(r_crc, w_tx_byte);
                    end
                end
                S_TX_FCS: if (w_tx_fall) begin
                    if (r_fcs_cnt == 4'd8) begin
                        TX_EN      <= 1'b0;
                        TX_DATA    <= 4'd0;
                        r_tx_ready <= 1'b1;
                    end else begin
                        TX_DATA   <= w_fcs_nib;
                        r_fcs_cnt <= r_fcs_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Nibbles arrive low first, so the previous nibble is always the low half.
    assign w_rx_byte = {RX_DATA, r_rx_prev};
    assign w_rx_wr   = (r_rx_state == S_RX_DATA) && w_rx_rise && RX_DV && r_rx_nib && !r_rx_cnt[BUF_W];
    assign w_rx_accept = (r_mac_ok | r_bc_ok) &&
                         ((BUF_W+2)'(r_rx_cnt) >= (BUF_W+2)'(r_rx_nbytes) + (BUF_W+2)'(18));

    always_comb begin
        w_mac_byte = 8'h00;
        case (r_rx_cnt[2:0])
            3'd0:    w_mac_byte = MAC_ADDR[47:40];
            3'd1:    w_mac_byte = MAC_ADDR[39:32];
            3'd2:    w_mac_byte = MAC_ADDR[31:24];
            3'd3:    w_mac_byte = MAC_ADDR[23:16];
            3'd4:    w_mac_byte = MAC_ADDR[15:8];
            3'd5:    w_mac_byte = MAC_ADDR[7:0];
            default: w_mac_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= S_RX_IDLE;
        else     r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            S_RX_IDLE: if (w_rx_rise && RX_DV && !r_rx_ready) w_rx_state_nxt = S_RX_PRE;
            S_RX_PRE:  if (w_rx_rise) begin
                if (!RX_DV)                   w_rx_state_nxt = S_RX_IDLE;
                else if (w_rx_byte == 8'hD5)  w_rx_state_nxt = S_RX_DATA;
            end
            S_RX_DATA: if (w_rx_rise && !RX_DV) w_rx_state_nxt = S_RX_DONE;
            S_RX_DONE: w_rx_state_nxt = S_RX_IDLE;
            default:   w_rx_state_nxt = S_RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_prev  <= 4'd0;
            r_rx_nib   <= 1'b0;
            r_rx_cnt   <= '0;
            r_mac_ok   <= 1'b0;
            r_bc_ok    <= 1'b0;
            r_rx_ready <= 1'b0;
        end else begin
            if (w_rx_rise) r_rx_prev <= RX_DATA;
            if (r_rx_state == S_RX_PRE && w_rx_state_nxt == S_RX_DATA) begin
                r_rx_nib <= 1'b0;
                r_rx_cnt <= '0;
                r_mac_ok <= 1'b1;
                r_bc_ok  <= 1'b1;
            end
            if (r_rx_state == S_RX_DATA && w_rx_rise && RX_DV) r_rx_nib <= ~r_rx_nib;
            if (w_rx_wr) begin
                r_rx_cnt <= r_rx_cnt + (BUF_W+1)'(1);
                if (r_rx_cnt < (BUF_W+1)'(6)) begin
                    r_mac_ok <= r_mac_ok && (w_rx_byte == w_mac_byte);
                    r_bc_ok  <= r_bc_ok && (w_rx_byte == 8'hFF);
                end
            end
            // Frame completion takes priority over a simultaneous RCVACK.
            if (r_rx_state == S_RX_DONE && w_rx_accept) r_rx_ready <= 1'b1;
            else if (w_rcvack)                          r_rx_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_wr) r_rx_mem[r_rx_cnt[BUF_W-1:0]] <= w_rx_byte;
    end
endmodule
`default_nettype wire

// File: tb/tb_iob_eth.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_iob_eth
// Brief    : MII loopback bench for iob_eth with TX scoreboard and RX model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_eth;
    localparam int          ADDR_W = 12;
    localparam int          BUF_W  = 11;
    localparam logic [47:0] c_mac  = 48'h01606e11020f;
    localparam int c_status = 0, c_send = 1, c_rcvack = 2, c_txn = 3, c_rxn = 4, c_data = 2048;
    localparam int c_frames = 8;

    logic       clk, rst, TX_CLK, ETH_RESETN, TX_EN;
    logic [3:0] TX_DATA;

    iob_eth_if #(.ADDR_W(ADDR_W)) bus ();

    iob_eth #(.ADDR_W(ADDR_W), .BUF_W(BUF_W), .MAC_ADDR(c_mac)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (bus),
        .ETH_RESETN(ETH_RESETN),
        .TX_CLK    (TX_CLK),
        .TX_DATA   (TX_DATA),
        .TX_EN     (TX_EN),
        .RX_CLK    (TX_CLK),
        .RX_DATA   (TX_DATA),
        .RX_DV     (TX_EN)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          tx_pulses = 0;
    logic [7:0]  exp_bytes[$];
    int          exp_len[$];
    logic [7:0]  frame[$];
    logic [31:0] crc_tab [256];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        TX_CLK = 1'b0;
        #2;
        forever #20 TX_CLK = ~TX_CLK;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cpu_write(input int a, input logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a[ADDR_W-1:0]; bus.data_in = d;
        @(negedge clk);
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic cpu_read(input int a, output logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a[ADDR_W-1:0];
        @(negedge clk);
        d = bus.data_out;
        bus.sel = 1'b0;
    endtask

    // Table-driven CRC-32 over frame bytes [from .. end].
    function automatic logic [31:0] ref_crc(input int from);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < frame.size(); i++) c = crc_tab[c[7:0] ^ frame[i]] ^ (c >> 8);
        return ~c;
    endfunction

    // Monitor: rebuild bytes from the MII TX stream and score against the queue.
    initial begin
        logic [7:0] got[$];
        logic [3:0] lo;
        bit         hi, in_frame;
        int         n;
        logic [7:0] e;
        hi = 0; in_frame = 0; lo = 4'd0;
        forever begin
            @(negedge TX_CLK);
            if (TX_EN === 1'b1) begin
                if (!in_frame) begin
                    in_frame = 1; hi = 0; got.delete(); tx_pulses++;
                end
                if (!hi) begin lo = TX_DATA; hi = 1; end
                else begin got.push_back({TX_DATA, lo}); hi = 0; end
            end else if (in_frame) begin
                in_frame = 0;
                if (exp_len.size() == 0) begin
                    check("tx_unexpected_frame", 32'(got.size()), 32'd0);
                end else begin
                    n = exp_len.pop_front();
                    check("tx_frame_len", 32'(got.size()), 32'(n));
                    for (int i = 0; i < n; i++) begin
                        e = exp_bytes.pop_front();
                        if (i < got.size()) check($sformatf("tx_byte[%0d]", i), 32'(got[i]), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, fcs, c;
        logic [47:0] dst;
        logic [7:0]  e;
        int          n, rxn, kind, budget, rx_len, body;
        bit          accept;

        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
        rst = 1'b1;
        for (int t = 0; t < 256; t++) begin
            c = 32'(t);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[t] = c;
        end

        repeat (10) @(negedge clk);
        check("reset_tx_en", 32'(TX_EN), 32'd0);
        check("reset_eth_resetn", 32'(ETH_RESETN), 32'd0);
        check("reset_data_out", bus.data_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("eth_resetn_release", 32'(ETH_RESETN), 32'd1);
        cpu_read(c_status, rd); check("reset_status", rd, 32'd1);
        cpu_read(c_txn, rd);    check("reset_tx_nbytes", rd, 32'd0);
        cpu_read(c_rxn, rd);    check("reset_rx_nbytes", rd, 32'd0);

        cpu_write(c_txn, 32'd100);
        cpu_read(c_txn, rd);    check("tx_nbytes_readback", rd, 32'd100);
        cpu_write(c_rxn, 32'hFFFF_F123);
        cpu_read(c_rxn, rd);    check("rx_nbytes_masked", rd, 32'h123);
        cpu_write(7, 32'hDEAD_BEEF);
        cpu_read(7, rd);        check("unmapped_read", rd, 32'd0);

        for (int f = 0; f < c_frames; f++) begin
            kind = f % 4;
            n = $urandom_range(46, 120);
            case (kind)
                0:       begin dst = c_mac;           rxn = n;                         end
                1:       begin dst = 48'hFFFF_FFFF_FFFF; rxn = n - $urandom_range(1, 20); end
                2:       begin dst = 48'h0200_0000_0001; rxn = n - 4;                  end
                default: begin dst = c_mac;           rxn = n + 1;                     end
            endcase

            frame.delete();
            repeat (15) frame.push_back(8'h55);
            frame.push_back(8'hD5);
            for (int b = 0; b < 6; b++) frame.push_back(dst[47-8*b -: 8]);
            for (int b = 0; b < 6; b++) frame.push_back(c_mac[47-8*b -: 8]);
            frame.push_back(8'h08);
            frame.push_back(8'h00);
            for (int b = 0; b < n; b++) frame.push_back(8'($urandom_range(0, 255)));

            body   = frame.size() - 16;
            rx_len = body + 4;
            fcs    = ref_crc(16);
            accept = (dst == c_mac || dst == 48'hFFFF_FFFF_FFFF) && (rx_len >= rxn + 18);

            cpu_write(c_txn, 32'(n));
            cpu_write(c_rxn, 32'(rxn));
            for (int i = 0; i < frame.size(); i++) cpu_write(c_data + i, {24'd0, frame[i]});

            foreach (frame[i]) exp_bytes.push_back(frame[i]);
            for (int b = 0; b < 4; b++) exp_bytes.push_back(fcs[8*b +: 8]);
            exp_len.push_back(frame.size() + 4);

            cpu_write(c_send, 32'd1);
            repeat (3) @(negedge clk);
            cpu_read(c_status, rd);
            check("busy_tx_ready", 32'(rd[0]), 32'd0);
            cpu_write(c_send, 32'd1);

            budget = 0;
            do begin
                cpu_read(c_status, rd);
                budget++;
            end while (rd[0] !== 1'b1 && budget < 5000);
            check("tx_done", 32'(rd[0]), 32'd1);

            repeat (30) @(negedge clk);
            cpu_read(c_status, rd);
            check($sformatf("rx_ready_frame%0d", f), 32'(rd[1]), 32'(accept));

            if (accept) begin
                for (int i = 0; i < rx_len; i++) begin
                    e = (i < body) ? frame[16 + i] : fcs[8*(i - body) +: 8];
                    cpu_read(c_data + i, rd);
                    check($sformatf("rx_byte[%0d]", i), rd, {24'd0, e});
                end
            end

            cpu_write(c_rcvack, 32'd1);
            cpu_read(c_status, rd);
            check("after_rcvack_status", rd, 32'd1);
        end

        repeat (100) @(negedge clk);
        check("tx_en_pulses", 32'(tx_pulses), 32'(c_frames));
        check("scoreboard_drained", 32'(exp_len.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
